// File: rtl/bcd_count_n.sv
// N-digit BCD up/down counter with a saturating or wrapping terminal.
// The binary terminal count is clamped and then converted to BCD by a sequential double-dabble.

module bcd_count_lane (
  input  logic [3:0] d,
  input  logic       up,
  input  logic       ci,
  input  logic [3:0] s,
  output logic [3:0] q,
  output logic [3:0] adj
);
  always_comb begin
    q   = d;
    adj = (s >= 4'd5) ? s + 4'd3 : s;
    if (ci) begin
      if (up) q = (d == 4'd9) ? 4'd0 : d + 4'd1;
      else    q = (d == 4'd0) ? 4'd9 : d - 4'd1;
    end
  end
endmodule

module bcd_count_n #(
  parameter int DIGITS = 2,
  parameter int MAX_W  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [MAX_W-1:0]      max_count,
  input  logic                  up,
  input  logic                  wrap,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  ready,
  output logic                  done
);
  localparam int CW = $clog2(MAX_W) + 1;

  function automatic logic [63:0] pow10m1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] LIM = pow10m1(DIGITS);

  typedef enum logic [1:0] {IDLE, CONV, COUNT, HOLD} state_t;

  state_t                   state_q, state_d;
  logic [DIGITS-1:0][3:0]   cnt_q, cnt_d, term_q, term_d, start_q, start_d;
  logic [DIGITS-1:0][3:0]   cnt_step, sc_adj;
  logic [4*DIGITS-1:0]      sc_q, sc_d, sc_adj_f, sc_shift;
  logic [MAX_W-1:0]         bin_q, bin_d, max_clamped;
  logic [CW-1:0]            bits_q, bits_d;
  logic                     up_q, up_d, wrap_q, wrap_d;
  logic                     ready_q, ready_d, done_q, done_d;
  logic [DIGITS-1:0]        cy;

  // Clamp in binary so the conversion never overflows the digit scratch
  assign max_clamped = (64'(max_count) > LIM) ? MAX_W'(LIM) : max_count;

  assign cy[0] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_lane
    if (i > 0) begin : g_cy
      assign cy[i] = cy[i-1] & (up_q ? (cnt_q[i-1] == 4'd9) : (cnt_q[i-1] == 4'd0));
    end
    bcd_count_lane u_lane (
      .d   (cnt_q[i]),
      .up  (up_q),
      .ci  (cy[i]),
      .s   (sc_q[4*i +: 4]),
      .q   (cnt_step[i]),
      .adj (sc_adj[i])
    );
  end

  assign sc_adj_f = sc_adj;
  assign sc_shift = {sc_adj_f[4*DIGITS-2:0], bin_q[MAX_W-1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    term_d  = term_q;
    start_d = start_q;
    sc_d    = sc_q;
    bin_d   = bin_q;
    bits_d  = bits_q;
    up_d    = up_q;
    wrap_d  = wrap_q;
    ready_d = ready_q;
    done_d  = done_q;
    if (!run) begin
      bin_d   = max_clamped;
      up_d    = up;
      wrap_d  = wrap;
      sc_d    = '0;
      bits_d  = '0;
      cnt_d   = '0;
      ready_d = 1'b0;
      done_d  = 1'b0;
      state_d = CONV;
    end else begin
      case (state_q)
        CONV: begin
          sc_d   = sc_shift;
          bin_d  = bin_q << 1;
          bits_d = bits_q + CW'(1);
          if (bits_q == CW'(MAX_W - 1)) begin
            ready_d = 1'b1;
            term_d  = up_q ? sc_shift : '0;
            start_d = up_q ? '0 : sc_shift;
            cnt_d   = up_q ? '0 : sc_shift;
            // Only max=0 makes start and terminal coincide
            if (sc_shift == '0) begin
              done_d  = 1'b1;
              state_d = HOLD;
            end else begin
              state_d = COUNT;
            end
          end
        end
        COUNT: begin
          if (done_q) begin
            cnt_d  = start_q;
            done_d = 1'b0;
          end else if (cnt_step == term_q) begin
            cnt_d  = term_q;
            done_d = 1'b1;
            if (!wrap_q) state_d = HOLD;
          end else begin
            cnt_d = cnt_step;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      term_q  <= '0;
      start_q <= '0;
      sc_q    <= '0;
      bin_q   <= '0;
      bits_q  <= '0;
      up_q    <= 1'b1;
      wrap_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      term_q  <= term_d;
      start_q <= start_d;
      sc_q    <= sc_d;
      bin_q   <= bin_d;
      bits_q  <= bits_d;
      up_q    <= up_d;
      wrap_q  <= wrap_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign digits = cnt_q;
  assign ready  = ready_q;
  assign done   = done_q;
endmodule

// File: doc/bcd_count_n.md
# bcd_count_n

Parametrised N-digit BCD counter, the successor to the two-digit `bcd_count_7`. It takes a binary terminal count and converts it to BCD internally with a sequential shift-add-3 (double-dabble) converter, clamping it to the largest displayable value. It then counts up or down under `run`, in either saturating or wrapping mode. Its packed BCD output drives the board's seven-segment digit decoders.

## Interface
- `DIGITS`, 2: number of BCD digits; displayable range 0 .. 10^DIGITS-1.
- `MAX_W`, 7: width of the binary `max_count` input; also the conversion length in cycles.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `run` input 1: 0 = clear and load a new configuration; 1 = count.
- `max_count` input MAX_W: binary terminal count; sampled only while `run`=0.
- `up` input 1: 1 = count up from 0 to max; 0 = count down from max to 0. Sampled with `max_count`.
- `wrap` input 1: 0 = stop at the terminal value; 1 = reload the start value and continue. Sampled with `max_count`.
- `digits` output 4*DIGITS: packed BCD count; `digits[3:0]` is the units digit.
- `ready` output 1: conversion complete; the counter is armed.
- `done` output 1: terminal value reached. Level in saturate mode; one-cycle pulse in wrap mode.

## Operation
- States: IDLE, CONV, COUNT, HOLD.
- Reset, which has priority over everything: state IDLE, `digits`=0, `ready`=0, `done`=0, latched config cleared (max=0, up=1, wrap=0).
- IDLE: outputs held. Any edge with `run`=0 moves to CONV.
- Any edge with `run`=0, from any state, does all of the following:
  - latches `max_count`, `up` and `wrap`;
  - clamps the latched max to 10^DIGITS-1 if it is larger, comparing in binary before conversion;
  - clears the BCD scratch and the bit counter;
  - sets `digits`=0, `ready`=0, `done`=0, and enters or restarts CONV.
- Consequently, holding `run`=0 keeps restarting CONV. The value in effect is the one present on the last `run`=0 edge.
- CONV: one double-dabble step per edge: add 3 to each scratch nibble that is ≥5, then shift in the next binary MSB.
  - After MAX_W steps, `ready`=1 and `digits` = start value: 0 if up, converted max if down.
  - The next state is COUNT, or HOLD if start equals terminal.
  - `run` changing to 1 during CONV does not disturb the conversion.
- COUNT, with `run`=1: one BCD step per edge.
  - Up: increment units; a digit of 9 becomes 0 and carries.
  - Down: decrement units; a digit of 0 becomes 9 and borrows.
  - When the next value equals the terminal (max if up, 0 if down):
    - `wrap`=0: load the terminal, set `done`=1, go to HOLD.
    - `wrap`=1: load the terminal and pulse `done` for that cycle. The next edge loads the start value with `done`=0 and stays in COUNT.
- HOLD: `digits` and `done` frozen until `run`=0 or `reset`.
- Changes to `max_count`, `up` or `wrap` while `run`=1 have no effect.
- `run`=0 mid-count or mid-conversion aborts immediately, as above.
- Degenerate max=0: the terminal equals the start value. `done`=1 together with `ready`=1, `digits`=0, in HOLD, for both wrap settings.

## Timing
- Conversion latency: `ready` rises exactly MAX_W edges after the last edge that sampled `run`=0.
- First count step occurs at the first edge after `ready`=1 with `run`=1.
- Count rate: one step per clock. In saturate mode `done` asserts on the same edge that `digits` reaches the terminal.
- Wrap period: max+1 cycles, with `done` high for 1 of every max+1 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Defaults, max=73, up, wrap=0: `run` 0→1. `ready` rises 7 cycles after the last `run`=0 edge. `digits` steps 0x00..0x73, then `done`=1 and holds. Setting max=15 at count 0x20 leaves the terminal at 0x73.
- max=118, up, wrap=0: clamps. Counts 0x00..0x99, stops with `done`=1.
- max=15, down, wrap=1: starts at 0x15 and counts to 0x00 with a `done` pulse, then 0x15. Period 16 cycles.
- max=0, up and down: `ready` and `done` both 1, `digits`=0x00, no further change while `run`=1.
- Abort cases:
  - `reset` at count 0x42 → all outputs 0 next edge, IDLE; no counting until `run` goes 0 then 1.
  - `run`=0 mid-count → `digits`=0x00 and reconversion restarts.
- DIGITS=3, MAX_W=10: max=1023 clamps to 0x999. Covers the 0x099→0x100 and 0x998→0x999 carries in up mode, and the 0x100→0x099 borrow in down mode.
